// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream and writes
// little-endian 32-bit words into instruction memory. The core enable is
// raised only after the last word has been committed.
//
// Handshake: a byte is consumed on every rising edge where
// l_i_valid && l_o_ready. l_o_ready depends only on the current state.
// Nothing is consumed in IDLE, FLUSH, DONE or ERR.
module prog_loader #(
  parameter int IWIDTH      = 32,
  parameter int IMEM_AWIDTH = 10
) (
  input  logic                   l_clk,
  input  logic                   l_rst,
  input  logic                   l_i_start,
  input  logic [7:0]             l_i_byte,
  input  logic                   l_i_valid,
  output logic                   l_o_ready,
  output logic                   l_o_imem_we,
  output logic [IMEM_AWIDTH-1:0] l_o_imem_addr,
  output logic [IWIDTH-1:0]      l_o_imem_data,
  output logic                   l_o_ce,
  output logic                   l_o_busy,
  output logic                   l_o_done,
  output logic                   l_o_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  // Largest legal word count is the full memory, 2^IMEM_AWIDTH words.
  localparam logic [16:0] MAX_WORDS = 17'(1) << IMEM_AWIDTH;

  state_e                 state_q, state_d;
  logic [15:0]            len_q, len_d;
  logic [IMEM_AWIDTH:0]   idx_q, idx_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [23:0]            lane_q, lane_d;
  logic                   we_q, we_d;
  logic [IMEM_AWIDTH-1:0] addr_q, addr_d;
  logic [IWIDTH-1:0]      data_q, data_d;

  logic        accept;
  logic [15:0] n_full;
  logic [16:0] idx_inc;

  // Ready and status flags are pure decodes of the current state.
  always_comb begin
    l_o_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    l_o_busy  = l_o_ready || (state_q == S_FLUSH);
    l_o_done  = (state_q == S_DONE);
    l_o_ce    = (state_q == S_DONE);
    l_o_err   = (state_q == S_ERR);
  end

  assign accept        = l_i_valid && l_o_ready;
  assign n_full        = {l_i_byte, len_q[7:0]};
  // Index widened so the comparison against the full 16-bit count is exact.
  assign idx_inc       = 17'(idx_q) + 17'd1;
  assign l_o_imem_we   = we_q;
  assign l_o_imem_addr = addr_q;
  assign l_o_imem_data = data_q;

  // Next-state and datapath updates; write strobe defaults low so it pulses.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (l_i_start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[15:8], l_i_byte};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = n_full;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, n_full} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            cnt_d   = 2'd0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          cnt_d = cnt_q + 2'd1;
          case (cnt_q)
            2'd0: lane_d[7:0]   = l_i_byte;
            2'd1: lane_d[15:8]  = l_i_byte;
            2'd2: lane_d[23:16] = l_i_byte;
            default: begin
              // Fourth byte completes the word: register the write port.
              data_d = IWIDTH'({l_i_byte, lane_q});
              addr_d = idx_q[IMEM_AWIDTH-1:0];
              we_d   = 1'b1;
              idx_d  = idx_inc[IMEM_AWIDTH:0];
              if (idx_inc == {1'b0, len_q}) state_d = S_FLUSH;
            end
          endcase
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge l_clk) begin
    if (l_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a 16-word memory. Images are lists of words; the
// byte stream and the expected memory writes are both derived from that list.
module tb_prog_loader;
  localparam int AW = 4;
  localparam int W  = AW + 32;

  logic          l_clk = 1'b0;
  logic          l_rst;
  logic          l_i_start;
  logic [7:0]    l_i_byte;
  logic          l_i_valid;
  logic          l_o_ready;
  logic          l_o_imem_we;
  logic [AW-1:0] l_o_imem_addr;
  logic [31:0]   l_o_imem_data;
  logic          l_o_ce;
  logic          l_o_busy;
  logic          l_o_done;
  logic          l_o_err;

  prog_loader #(.IWIDTH(32), .IMEM_AWIDTH(AW)) dut (
    .l_clk(l_clk), .l_rst(l_rst), .l_i_start(l_i_start), .l_i_byte(l_i_byte),
    .l_i_valid(l_i_valid), .l_o_ready(l_o_ready), .l_o_imem_we(l_o_imem_we),
    .l_o_imem_addr(l_o_imem_addr), .l_o_imem_data(l_o_imem_data),
    .l_o_ce(l_o_ce), .l_o_busy(l_o_busy), .l_o_done(l_o_done), .l_o_err(l_o_err)
  );

  // Clock and global time limit
  always #5 l_clk = ~l_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  img_q[$];
  logic [W-1:0] mon_exp;
  logic         prev_we = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge l_clk);
    #1;
  endtask

  // Scoreboard monitor: every write strobe pops one expected {addr,data}.
  always @(negedge l_clk) begin
    if (l_o_imem_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 l_o_imem_addr, l_o_imem_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (prev_we || {l_o_imem_addr, l_o_imem_data} !== mon_exp) begin
          errors++;
          $display("FAIL imem_write: got addr %0h data %0h (we held %0b) expected addr %0h data %0h",
                   l_o_imem_addr, l_o_imem_data, prev_we, mon_exp[W-1:32], mon_exp[31:0]);
        end
      end
    end
    prev_we = l_o_imem_we;
  end

  // Driver: offer one byte, optionally after random idle cycles, until accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        l_i_valid = 1'b0;
        l_i_byte  = 8'($urandom);
        tick();
      end
    end
    l_i_valid = 1'b1;
    l_i_byte  = b;
    guard = 0;
    while (!l_o_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!l_o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready 0 expected 1 within 20 cycles");
    end
    tick();
    l_i_valid = 1'b0;
    l_i_byte  = 8'($urandom);
  endtask

  // Full load of img_q with declared count n; start_at >= 0 pulses start
  // before that data byte index to show it is ignored mid-load.
  task automatic run_load(input int n, input bit gaps, input int start_at);
    int base;
    logic [31:0] w;
    base = wr_count;
    l_i_start = 1'b1;
    tick();
    l_i_start = 1'b0;
    check("after_start {ready,busy,ce,done,err}",
          {l_o_ready, l_o_busy, l_o_ce, l_o_done, l_o_err}, 64'b11000);
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    if (n == 0) begin
      check("zero_len {ce,done,busy,ready}", {l_o_ce, l_o_done, l_o_busy, l_o_ready}, 64'b1100);
      tick();
      check("zero_len writes", 64'(wr_count - base), 64'd0);
      return;
    end
    if (n > (1 << AW)) begin
      check("oversize {err,ready,ce,busy}", {l_o_err, l_o_ready, l_o_ce, l_o_busy}, 64'b1000);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = img_q[i];
      exp_q.push_back({i[AW-1:0], w});
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k == start_at) begin
          l_i_start = 1'b1;
          tick();
          l_i_start = 1'b0;
          check("mid_start_ignored {busy,ready,ce}", {l_o_busy, l_o_ready, l_o_ce}, 64'b110);
        end
        send_byte(8'(w >> (8 * k)), gaps);
      end
    end
    // One cycle after the final byte: flushing, not yet enabled.
    check("flush {ce,ready,busy}", {l_o_ce, l_o_ready, l_o_busy}, 64'b001);
    tick();
    check("done {ce,done,busy,ready,err}", {l_o_ce, l_o_done, l_o_busy, l_o_ready, l_o_err},
          64'b11000);
    check("write_count", 64'(wr_count - base), 64'(n));
  endtask

  initial begin
    int base;
    logic [31:0] w;
    // Reset held two cycles with traffic and start asserted.
    l_rst     = 1'b1;
    l_i_start = 1'b0;
    l_i_valid = 1'b1;
    l_i_byte  = 8'($urandom);
    tick();
    l_i_start = 1'b1;
    l_i_byte  = 8'($urandom);
    tick();
    check("reset outputs", {l_o_ready, l_o_imem_we, l_o_imem_addr, l_o_imem_data,
                            l_o_ce, l_o_busy, l_o_done, l_o_err}, 64'd0);
    l_rst     = 1'b0;
    l_i_start = 1'b0;
    l_i_valid = 1'b0;
    tick();
    check("idle ready", {63'd0, l_o_ready}, 64'd0);

    // Two-word image back-to-back, then with random gaps.
    img_q = '{32'hDEADBEEF, 32'h12345678};
    run_load(2, 1'b0, -1);
    repeat (3) tick();
    check("post_load {ce,busy}", {l_o_ce, l_o_busy}, 64'b10);
    run_load(2, 1'b1, -1);

    // Zero length and oversize length.
    img_q = {};
    run_load(0, 1'b0, -1);
    run_load(17, 1'b0, -1);
    base = wr_count;
    repeat (4) begin
      l_i_valid = 1'b1;
      l_i_byte  = 8'($urandom);
      tick();
    end
    l_i_valid = 1'b0;
    check("err_hold {err,ready,writes}", {l_o_err, l_o_ready, 32'(wr_count - base)},
          {1'b1, 1'b0, 32'd0});

    // Full memory: 16 random words with gaps.
    img_q = {};
    for (int i = 0; i < 16; i++) img_q.push_back($urandom);
    run_load(16, 1'b1, -1);

    // Start pulsed mid-data, then a one-word restart from DONE.
    img_q = '{$urandom, $urandom};
    run_load(2, 1'b0, 5);
    img_q = '{$urandom};
    run_load(1, 1'b1, -1);

    // Reset after six data bytes of a three-word image.
    img_q = '{$urandom, $urandom, $urandom};
    l_i_start = 1'b1;
    tick();
    l_i_start = 1'b0;
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    exp_q.push_back({{AW{1'b0}}, img_q[0]});
    for (int b = 0; b < 6; b++) begin
      w = img_q[b / 4];
      send_byte(8'(w >> (8 * (b % 4))), 1'b0);
    end
    l_rst = 1'b1;
    tick();
    l_rst = 1'b0;
    check("mid_reset outputs", {l_o_ready, l_o_imem_we, l_o_imem_addr, l_o_imem_data,
                                l_o_ce, l_o_busy, l_o_done, l_o_err}, 64'd0);
    base = wr_count;
    repeat (5) begin
      l_i_valid = 1'b1;
      l_i_byte  = 8'($urandom);
      tick();
    end
    l_i_valid = 1'b0;
    check("after_reset {writes,ce}", {32'(wr_count - base), 31'd0, l_o_ce}, 64'd0);
    img_q = '{$urandom};
    run_load(1, 1'b0, -1);

    repeat (3) tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
